// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the pmem arbiter: FSM encoding, owner ids, default widths.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int MASK_W     = 8;

endpackage

// File: rtl/pmem_arb_grant.sv
// Fixed-priority winner select between IFU and LSU; grant[OWN_IFU]/grant[OWN_LSU] one-hot.
module pmem_arb_grant
  import pmem_arb_pkg::*;
#(
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) grant[LSU_FIRST ? OWN_LSU : OWN_IFU] = 1'b1;
    else if (lsu_valid)         grant[OWN_LSU] = 1'b1;
    else if (ifu_valid)         grant[OWN_IFU] = 1'b1;
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Single-outstanding arbiter sharing the pmem port between IFU and LSU.
// Optional WAIT-state watchdog enabled by defining PMEM_ARB_TIMEOUT_EN.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LSU_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rsp_rdata,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rsp_rdata,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t        state, state_nxt;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              owner_q;
  logic              accept, mem_acc, rsp_hit, rsp_done, tmo_hit;

  pmem_arb_grant #(.LSU_FIRST(LSU_FIRST != 0)) u_grant (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .grant     (grant)
  );

  assign ifu_req_ready = (state == IDLE) && grant[OWN_IFU];
  assign lsu_req_ready = (state == IDLE) && grant[OWN_LSU];
  assign accept        = ifu_req_ready || lsu_req_ready;
  assign mem_acc       = (state == REQ) && mem_req_ready;
  // pmem responses outside WAIT are dropped here
  assign rsp_hit       = (state == WAIT) && mem_rsp_valid;
  assign rsp_done      = (state == RSP) &&
                         ((owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready);

`ifdef PMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_q;

  // A response on the limit cycle wins over the timeout
  assign tmo_hit = (state == WAIT) && !mem_rsp_valid &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (mem_acc)              wait_cnt <= '0;
      else if (state == WAIT)   wait_cnt <= wait_cnt + 1'b1;
      if (tmo_hit)              tmo_q    <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)             state_nxt = REQ;
      REQ:     if (mem_acc)            state_nxt = WAIT;
      WAIT:    if (rsp_hit || tmo_hit) state_nxt = RSP;
      RSP:     if (rsp_done)           state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      owner_q <= OWN_IFU;
    end else begin
      if (accept) begin
        owner_q <= lsu_req_ready ? OWN_LSU : OWN_IFU;
        addr_q  <= lsu_req_ready ? lsu_req_addr : ifu_req_addr;
        wen_q   <= lsu_req_ready && lsu_req_wen;
        wdata_q <= lsu_req_ready ? lsu_req_wdata : '0;
        wmask_q <= lsu_req_ready ? lsu_req_wmask : '0;
      end
      if (rsp_hit) begin
        rdata_q <= wen_q ? '0 : mem_rsp_rdata;
        err_q   <= mem_rsp_err;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign ifu_rsp_valid = (state == RSP) && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (state == RSP) && (owner_q == OWN_LSU);
  assign ifu_rsp_rdata = ifu_rsp_valid ? rdata_q : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rdata_q : '0;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  assign owner = owner_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed requests, pmem model, decoupled response monitor.
module tb_pmem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready = 1, ifu_rsp_err;
  logic [31:0] ifu_req_addr = 0, ifu_rsp_rdata;
  logic lsu_req_valid = 0, lsu_req_ready, lsu_req_wen = 0, lsu_rsp_valid, lsu_rsp_ready = 1, lsu_rsp_err;
  logic [31:0] lsu_req_addr = 0, lsu_req_wdata = 0, lsu_rsp_rdata;
  logic [7:0]  lsu_req_wmask = 0;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [7:0]  mem_req_wmask;
  logic owner, busy, timeout_err;

  logic b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_err, b_lsu_req_ready, b_lsu_rsp_valid, b_lsu_rsp_err;
  logic [31:0] b_ifu_rsp_rdata, b_lsu_rsp_rdata, b_mem_req_addr, b_mem_req_wdata;
  logic b_mem_req_valid, b_mem_req_wen, b_owner, b_busy, b_timeout_err;
  logic [7:0] b_mem_req_wmask;

  int total = 0, bad = 0, cyc = 0;
  int last_lsu_rsp_cyc = 0;
  int stall = 0;
  logic mute = 0, inject = 0, rsp_pend = 0;
  logic [31:0] pend_data = 0;

  mreq_t exp_mem[$];
  rsp_t  exp_ifu[$], exp_lsu[$];
  logic  exp_own[$];

  pmem_arbiter #(.LSU_FIRST(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  // IFU-first twin sharing all inputs, used to observe the reversed priority
  pmem_arbiter #(.LSU_FIRST(0), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(b_ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(b_ifu_rsp_rdata),
    .ifu_rsp_err(b_ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(b_lsu_rsp_rdata),
    .lsu_rsp_err(b_lsu_rsp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(b_mem_req_addr),
    .mem_req_wen(b_mem_req_wen), .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .owner(b_owner), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0073;
      32'h8000_0004: return 32'h0000_0013;
      32'h8000_1000: return 32'h1234_5678;
      default:       return 32'hA5A5_A5A5;
    endcase
  endfunction

  // pmem model: ready decided per cycle at negedge, response one cycle after acceptance
  initial begin
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = rsp_pend || inject;
      mem_rsp_rdata = rsp_pend ? pend_data : (inject ? 32'hDEAD_DEAD : 32'h0);
      rsp_pend = 0;
      inject = 0;
      mem_req_ready = (stall == 0);
      if (mem_req_valid && stall > 0) stall--;
      if (mem_req_valid && mem_req_ready && !mute) begin
        rsp_pend = 1;
        pend_data = mem_data(mem_req_addr);
      end
    end
  end

  // Monitor: compares every handshake against the scoreboard queues
  initial forever begin
    @(negedge clk); #2;
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem.size() == 0) check("mem_req_unexpected", 1, 0);
        else check("mem_req_fields", {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, exp_mem.pop_front());
      end
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        if (exp_own.size() == 0 || exp_ifu.size() == 0) check("ifu_rsp_unexpected", 1, 0);
        else begin
          check("ifu_rsp_owner", owner, exp_own.pop_front());
          check("ifu_rsp_data", {ifu_rsp_rdata, ifu_rsp_err}, exp_ifu.pop_front());
        end
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        last_lsu_rsp_cyc = cyc;
        if (exp_own.size() == 0 || exp_lsu.size() == 0) check("lsu_rsp_unexpected", 1, 0);
        else begin
          check("lsu_rsp_owner", owner, exp_own.pop_front());
          check("lsu_rsp_data", {lsu_rsp_rdata, lsu_rsp_err}, exp_lsu.pop_front());
        end
      end
      check("rsp_exclusive", ifu_rsp_valid & lsu_rsp_valid, 0);
      if (!ifu_rsp_valid) check("ifu_idle_rdata", ifu_rsp_rdata, 0);
      if (!lsu_rsp_valid) check("lsu_idle_rdata", lsu_rsp_rdata, 0);
    end
  end

  function automatic logic probe(input int which);
    case (which)
      0:       return ifu_rsp_valid;
      1:       return lsu_rsp_valid;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm);
    int n = 0;
    while (!probe(which) && n < 200) begin @(negedge clk); #2; n++; end
    if (!probe(which)) check(nm, 0, 1);
  endtask

  task automatic ifu_req(input logic [31:0] a, output int gcyc);
    int n = 0;
    ifu_req_valid = 1; ifu_req_addr = a;
    #1;
    while (!ifu_req_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!ifu_req_ready) check("ifu_grant_timeout", 0, 1);
    gcyc = cyc;
    exp_mem.push_back('{addr: a, wen: 1'b0, wdata: 32'h0, wmask: 8'h0});
    @(negedge clk);
    ifu_req_valid = 0; ifu_req_addr = 0;
  endtask

  task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [7:0] m, output int gcyc);
    int n = 0;
    lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = w; lsu_req_wdata = d; lsu_req_wmask = m;
    #1;
    while (!lsu_req_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!lsu_req_ready) check("lsu_grant_timeout", 0, 1);
    gcyc = cyc;
    exp_mem.push_back('{addr: a, wen: w, wdata: d, wmask: m});
    @(negedge clk);
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
  endtask

  initial begin
    int gi, gl;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctl", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err,
                        lsu_rsp_err, mem_req_valid, mem_req_wen, owner, busy, timeout_err}, 0);
    check("reset_data", {ifu_rsp_rdata, lsu_rsp_rdata, mem_req_addr, mem_req_wdata}, 0);
    check("reset_b", {b_ifu_req_ready, b_lsu_req_ready, b_ifu_rsp_valid, b_lsu_rsp_valid, b_ifu_rsp_err,
                      b_lsu_rsp_err, b_mem_req_valid, b_mem_req_wen, b_owner, b_busy, b_timeout_err,
                      |{b_ifu_rsp_rdata, b_lsu_rsp_rdata, b_mem_req_addr, b_mem_req_wdata,
                        b_mem_req_wmask, mem_req_wmask}}, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    // IFU read alone: response 3 cycles after the accept cycle
    exp_own.push_back(0);
    exp_ifu.push_back('{rdata: 32'h0010_0073, err: 1'b0});
    ifu_req(32'h8000_0000, gi);
    wait_for(0, "ifu_rsp_wait");
    check("ifu_latency", cyc - gi, 3);
    check("ifu_owner", owner, 0);
    wait_for(2, "idle_wait1");

    // Simultaneous requests: LSU first here, IFU first on the twin
    exp_own.push_back(1); exp_own.push_back(0);
    exp_lsu.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    exp_ifu.push_back('{rdata: 32'h0000_0013, err: 1'b0});
    @(negedge clk);
    fork
      lsu_req(32'h8000_1000, 1'b0, 32'h0, 8'h0F, gl);
      ifu_req(32'h8000_0004, gi);
      begin
        #1;
        check("grant_lsu_first", {ifu_req_ready, lsu_req_ready}, 2'b01);
        check("grant_ifu_first_b", {b_ifu_req_ready, b_lsu_req_ready}, 2'b10);
        @(negedge clk); #1;
        check("owner_order", {owner, b_owner}, 2'b10);
      end
    join
    check("ifu_after_lsu_rsp", gi - last_lsu_rsp_cyc, 1);
    wait_for(2, "idle_wait2");

    // Store with 5-cycle pmem back-pressure; pmem read data must not leak into the store response
    stall = 5;
    exp_own.push_back(1);
    exp_lsu.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    lsu_req(32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 8'h0F, gl);
    repeat (5) begin
      #3;
      check("stall_hold", {mem_req_valid, mem_req_ready, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask},
            {2'b10, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 8'h0F});
      @(negedge clk);
    end
    wait_for(2, "idle_wait3");

    // Response back-pressure with a competing IFU request
    lsu_rsp_ready = 0;
    exp_own.push_back(1); exp_own.push_back(0);
    exp_lsu.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    exp_ifu.push_back('{rdata: 32'h0010_0073, err: 1'b0});
    lsu_req(32'h8000_1000, 1'b0, 32'h0, 8'hFF, gl);
    wait_for(1, "bp_rsp_wait");
    repeat (4) begin
      @(negedge clk);
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
      #1;
      check("bp_hold", {lsu_rsp_valid, lsu_rsp_rdata, ifu_req_ready}, {1'b1, 32'h1234_5678, 1'b0});
    end
    @(negedge clk);
    lsu_rsp_ready = 1;
    ifu_req(32'h8000_0000, gi);
    wait_for(2, "idle_wait4");

    // Reset while waiting on pmem, then a stale response arrives
    mute = 1;
    @(negedge clk);
    ifu_req(32'h8000_0004, gi);
    @(negedge clk); #1;
    check("in_wait_busy", {busy, mem_req_valid}, 2'b10);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 inject = 1;
    #1;
    check("mid_reset_ctl", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, busy, owner, ifu_req_ready}, 0);
    check("mid_reset_data", {mem_req_addr, mem_req_wdata, mem_req_wmask, ifu_rsp_rdata}, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("stale_dropped", {ifu_rsp_valid, lsu_rsp_valid, busy}, 0);
    end
    mute = 0;

`ifdef PMEM_ARB_TIMEOUT_EN
    mute = 1;
    exp_own.push_back(1);
    exp_lsu.push_back('{rdata: 32'h0, err: 1'b1});
    lsu_req(32'h8000_1000, 1'b0, 32'h0, 8'hFF, gl);
    wait_for(1, "tmo_rsp_wait");
    check("tmo_flag", timeout_err, 1);
    wait_for(2, "idle_wait5");
    mute = 0;
    repeat (3) @(negedge clk);
    #1 check("tmo_sticky", timeout_err, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 check("tmo_cleared", timeout_err, 0);
`else
    #1 check("tmo_tied_off", timeout_err, 0);
`endif

    repeat (2) @(negedge clk);
    check("queues_drained", exp_own.size() + exp_ifu.size() + exp_lsu.size() + exp_mem.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
